// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: holds one instruction's writeback candidates, aligns load data,
// and counts retired register writes. Define MEM_WB_MISALIGN_CHK_EN to enable misaligned-load flagging.
module mem_wb_stage #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_alu,
  input  logic [DataWidth-1:0] in_mem_rdata,
  input  logic [DataWidth-1:0] in_pc4,
  input  logic [DataWidth-1:0] in_imm,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_wb_sel,
  input  logic [4:0]           in_rd,
  input  logic                 in_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] wb_alu,
  output logic [DataWidth-1:0] wb_load,
  output logic [DataWidth-1:0] wb_pc4,
  output logic [DataWidth-1:0] wb_imm,
  output logic [1:0]           wb_sel,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic                 wb_misalign,
  output logic [31:0]          retire_cnt
);

  function automatic logic [DataWidth-1:0] align_load(input logic [2:0]           f3,
                                                      input logic [1:0]           off,
                                                      input logic [DataWidth-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DataWidth-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = DataWidth'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = DataWidth'(h);
      3'b101:  r = {16'd0, h};
      3'b010:  r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef MEM_WB_MISALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] sel, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic m;
    m = 1'b0;
    if (sel == 2'b01) begin
      if ((f3 == 3'b001 || f3 == 3'b101) && off[0]) m = 1'b1;
      if (f3 == 3'b010 && off != 2'd0)              m = 1'b1;
    end
    return m;
  endfunction
`endif

  logic                 vld_p1;
  logic [DataWidth-1:0] alu_p1, load_p1, pc4_p1, imm_p1;
  logic [1:0]           sel_p1;
  logic [4:0]           rd_p1;
  logic                 we_p1;
  logic                 mis_p1;
  logic [31:0]          cnt_p1;
  logic                 accept, retire;

  assign in_ready = !vld_p1 | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  assign retire   = vld_p1 & out_ready;

  // ---- p0 -> p1: accept into the holding register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      alu_p1  <= '0;
      load_p1 <= '0;
      pc4_p1  <= '0;
      imm_p1  <= '0;
      sel_p1  <= '0;
      rd_p1   <= '0;
      we_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      alu_p1  <= in_alu;
      load_p1 <= align_load(in_funct3, in_alu[1:0], in_mem_rdata);
      pc4_p1  <= in_pc4;
      imm_p1  <= in_imm;
      sel_p1  <= in_wb_sel;
      rd_p1   <= in_rd;
      we_p1   <= in_we;
    end else if (retire) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef MEM_WB_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                mis_p1 <= 1'b0;
    else if (!flush && accept) mis_p1 <= misaligned(in_wb_sel, in_funct3, in_alu[1:0]);
  end
`else
  assign mis_p1 = 1'b0;
`endif

  // A retire coinciding with flush still counts, so this ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt_p1 <= '0;
    else if (retire && wb_we) cnt_p1 <= cnt_p1 + 32'd1;
  end

  assign out_valid   = vld_p1;
  assign wb_alu      = alu_p1;
  assign wb_load     = load_p1;
  assign wb_pc4      = pc4_p1;
  assign wb_imm      = imm_p1;
  assign wb_sel      = sel_p1;
  assign wb_rd       = rd_p1;
  assign wb_misalign = vld_p1 & mis_p1;
  assign wb_we       = vld_p1 & we_p1 & (rd_p1 != 5'd0) & !mis_p1;
  assign retire_cnt  = cnt_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: alignment, handshake, stall, flush, reset and retire counting.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_we, out_valid, out_ready;
  logic [31:0] in_alu, in_mem_rdata, in_pc4, in_imm;
  logic [2:0]  in_funct3;
  logic [1:0]  in_wb_sel, wb_sel;
  logic [4:0]  in_rd, wb_rd;
  logic [31:0] wb_alu, wb_load, wb_pc4, wb_imm, retire_cnt;
  logic        wb_we, wb_misalign;
  int          n_chk = 0;
  int          n_pass = 0;

  mem_wb_stage #(.DataWidth(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_mem_rdata(in_mem_rdata), .in_pc4(in_pc4), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_wb_sel(in_wb_sel), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .wb_alu(wb_alu), .wb_load(wb_load),
    .wb_pc4(wb_pc4), .wb_imm(wb_imm), .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] f3, input logic [1:0] sel, input logic [4:0] rd,
                       input logic we);
    in_valid     = v;
    in_alu       = alu;
    in_mem_rdata = rdata;
    in_pc4       = alu + 32'h4000;
    in_imm       = alu ^ 32'hFFFF_0000;
    in_funct3    = f3;
    in_wb_sel    = sel;
    in_rd        = rd;
    in_we        = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 2'd0, 5'd0, 1'b0);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_cnt",       retire_cnt,         32'd0);
    tick();
    rst_n = 1'b1;

    // LB at offset 3, downstream stalled
    drive(1'b1, 32'h0000_1003, 32'h80FF_1234, 3'b000, 2'b01, 5'd0, 1'b0);
    tick();
    check("lb_valid",    {31'd0, out_valid}, 32'd1);
    check("lb_load",     wb_load,            32'hFFFF_FF80);
    check("lb_alu",      wb_alu,             32'h0000_1003);
    check("lb_sel",      {30'd0, wb_sel},    32'd1);
    check("lb_in_ready", {31'd0, in_ready},  32'd0);

    // asynchronous reset while FULL
    rst_n = 1'b0;
    #1;
    check("arst_valid",    {31'd0, out_valid}, 32'd0);
    check("arst_load",     wb_load,            32'd0);
    check("arst_alu",      wb_alu,             32'd0);
    check("arst_sel",      {30'd0, wb_sel},    32'd0);
    check("arst_in_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'h80FF_1234, 3'b100, 2'b01, 5'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    check("lbu_load", wb_load, 32'h0000_0080);
    drive(1'b1, 32'h0000_1002, 32'h80FF_1234, 3'b101, 2'b01, 5'd0, 1'b0);
    tick();
    check("lhu_load", wb_load, 32'h0000_80FF);
    drive(1'b1, 32'h0000_1002, 32'h80FF_1234, 3'b001, 2'b01, 5'd0, 1'b0);
    tick();
    check("lh_hi_load", wb_load, 32'hFFFF_80FF);
    drive(1'b1, 32'h0000_1000, 32'h80FF_1234, 3'b001, 2'b01, 5'd0, 1'b0);
    tick();
    check("lh_lo_load", wb_load, 32'h0000_1234);
    drive(1'b1, 32'h0000_1001, 32'h80FF_1234, 3'b000, 2'b01, 5'd0, 1'b0);
    tick();
    check("lb_off1_load", wb_load, 32'h0000_0012);
    drive(1'b1, 32'h0000_1000, 32'h80FF_1234, 3'b011, 2'b01, 5'd0, 1'b0);
    tick();
    check("f3_011_load", wb_load, 32'h0000_0000);

    // write to x0
    drive(1'b1, 32'h0000_DEAD, 32'h0, 3'b010, 2'b00, 5'd0, 1'b1);
    tick();
    check("x0_valid", {31'd0, out_valid}, 32'd1);
    check("x0_we",    {31'd0, wb_we},     32'd0);
    in_valid = 1'b0;
    tick();
    check("x0_drain", {31'd0, out_valid}, 32'd0);
    check("x0_cnt",   retire_cnt,         32'd0);

    // four back-to-back instructions
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h100 + i, 32'h0, 3'b010, 2'b00, 5'(i), 1'b1);
      tick();
      check("b2b_rd",  {27'd0, wb_rd},    i);
      check("b2b_alu", wb_alu,            32'h100 + i);
      check("b2b_we",  {31'd0, wb_we},    32'd1);
      check("b2b_imm", wb_imm,            (32'h100 + i) ^ 32'hFFFF_0000);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drain", {31'd0, out_valid}, 32'd0);
    check("b2b_cnt",   retire_cnt,         32'd4);

    // stall for three cycles while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_AAAA, 32'h0, 3'b010, 2'b10, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'h0000_BBBB, 32'h0, 3'b010, 2'b00, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_alu",   wb_alu,            32'h0000_AAAA);
      check("stall_pc4",   wb_pc4,            32'h0000_EAAA);
      check("stall_rd",    {27'd0, wb_rd},    32'd7);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    check("stall_cnt", retire_cnt, 32'd4);
    out_ready = 1'b1;
    #1;
    check("release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("release_alu", wb_alu,         32'h0000_BBBB);
    check("release_rd",  {27'd0, wb_rd}, 32'd8);
    check("release_cnt", retire_cnt,     32'd5);

    // flush with a new input offered while FULL and retiring
    flush = 1'b1;
    drive(1'b1, 32'h0000_CCCC, 32'h0, 3'b010, 2'b00, 5'd9, 1'b1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_we",    {31'd0, wb_we},     32'd0);
    check("flush_cnt",   retire_cnt,         32'd6);
    tick();
    check("flush_dropped", {31'd0, out_valid}, 32'd0);
    check("flush_cnt2",    retire_cnt,         32'd6);

    // misaligned LW
    drive(1'b1, 32'h0000_1002, 32'h80FF_1234, 3'b010, 2'b01, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
`ifdef MEM_WB_MISALIGN_CHK_EN
    check("mis_flag", {31'd0, wb_misalign}, 32'd1);
    check("mis_we",   {31'd0, wb_we},       32'd0);
    tick();
    check("mis_cnt",  retire_cnt,           32'd6);
`else
    check("mis_flag", {31'd0, wb_misalign}, 32'd0);
    check("mis_we",   {31'd0, wb_we},       32'd1);
    check("mis_load", wb_load,              32'h80FF_1234);
    tick();
    check("mis_cnt",  retire_cnt,           32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
